// File: rtl/dff_rr_write_arbiter_if.sv
// Requester-side bus of the round-robin write arbiter: requests, data, clear and the
// acknowledge/status returned by the arbiter, plus the FSM state and pointer for observation.
interface dff_rr_write_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  // Handshake: a requester holds req[i] high with stable wdata until it sees ack[i] for
  // one cycle, then drops req[i]; a req still high after the ack cycle is a new request.
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic               clr;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   dout;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic [0:0]         state;
  logic [IDW-1:0]     ptr;

  modport master (
    output req, wdata, clr,
    input  ack, dout, grant_id, busy, state, ptr
  );

  modport slave (
    input  req, wdata, clr,
    output ack, dout, grant_id, busy, state, ptr
  );
endinterface

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin arbiter granting one of N requesters per two cycles write access to a
// shared WIDTH-bit register, held in a reset-able D flip-flop storage element.
module dff_rr_write_store #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clr wins over load; the arbiter never asserts both together.
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= d;
  end
endmodule

module dff_rr_write_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  dff_rr_write_arbiter_if.slave  bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_id;
  logic [N-1:0]     ack;
  logic [WIDTH-1:0] dout;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   next_ptr;
  logic [N-1:0]     win_onehot;
  logic [WIDTH-1:0] win_data;
  logic             do_grant;
  logic             do_clr;

  // Search ptr, ptr+1, ... wrapping mod N; the first set request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == win) begin
        win_onehot[i] = 1'b1;
        win_data      = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = (int'(win) == N - 1) ? '0 : win + IDW'(1);

  // Clear has priority over a grant in IDLE; in ACK it only zeroes the register.
  assign do_clr   = bus.clr;
  assign do_grant = (state == ST_IDLE) && !bus.clr && found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      ack      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= '0;
          if (do_grant) begin
            ack      <= win_onehot;
            grant_id <= win;
            ptr      <= next_ptr;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          ack   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dff_rr_write_store #(.WIDTH(WIDTH)) u_store (
    .clk  (clk),
    .rst  (rst),
    .clr  (do_clr),
    .load (do_grant),
    .d    (win_data),
    .q    (dout)
  );

  assign bus.ack      = ack;
  assign bus.dout     = dout;
  assign bus.grant_id = grant_id;
  assign bus.busy     = (state == ST_ACK);
  assign bus.state    = state;
  assign bus.ptr      = ptr;
endmodule
